// File: rtl/rf_pkg.sv
// Shared constants for the banked PIC-style register file: SFR addresses,
// write-command encodings, STATUS/OPTION bit positions and reset values.
package rf_pkg;

    localparam logic [4:0] ADDR_INDF       = 5'h00;
    localparam logic [4:0] ADDR_TMR0       = 5'h01;
    localparam logic [4:0] ADDR_PCL        = 5'h02;
    localparam logic [4:0] ADDR_STATUS     = 5'h03;
    localparam logic [4:0] ADDR_FSR        = 5'h04;
    localparam logic [4:0] ADDR_PORTA      = 5'h05;
    localparam logic [4:0] ADDR_PORTB      = 5'h06;
    localparam logic [4:0] ADDR_PORTC      = 5'h07;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'b000,
        CMD_STATUS = 3'b001,
        CMD_FILE   = 3'b010,
        CMD_OPTION = 3'b011,
        CMD_FSR    = 3'b100
    } wr_cmd_e;

    localparam int STATUS_C   = 0;
    localparam int STATUS_DC  = 1;
    localparam int STATUS_Z   = 2;
    localparam int STATUS_PD  = 3;
    localparam int STATUS_TO  = 4;
    localparam int STATUS_PA0 = 5;

    localparam int OPT_PS_LSB = 0;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PSA    = 3;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_T0CS   = 5;

    localparam logic [7:0] STATUS_RST = 8'h18;
    localparam logic [7:0] FSR_RST    = 8'h00;
    localparam logic [5:0] OPTION_RST = 6'h3F;

    // Low PS+1 bits of the prescaler: 1:2 for PS=0 up to 1:256 for PS=7.
    function automatic logic [7:0] prescale_mask(input logic [2:0] ps);
        return 8'hFF >> (3'd7 - ps);
    endfunction

endpackage

// File: rtl/tmr0_prescaler.sv
// TMR0 with its 8-bit prescaler and the two-tick inhibit that follows a
// software write to TMR0.
module tmr0_prescaler
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic [5:0] option_i,
    output logic [7:0] tmr0_o
);

    logic [7:0] tmr0_q, tmr0_d;
    logic [7:0] pre_q, pre_d;
    logic [1:0] inhibit_q, inhibit_d;
    logic       unused_t0se;

    assign unused_t0se = option_i[OPT_T0SE];

    always_comb begin
        tmr0_d    = tmr0_q;
        pre_d     = pre_q;
        inhibit_d = inhibit_q;
        // A load beats a coincident tick, so that tick's increment is dropped.
        if (load_i) begin
            tmr0_d    = load_data_i;
            pre_d     = 8'h00;
            inhibit_d = 2'd2;
        end else if (tick_i && !option_i[OPT_T0CS]) begin
            if (inhibit_q != 2'd0) begin
                inhibit_d = inhibit_q - 2'd1;
            end else if (option_i[OPT_PSA]) begin
                tmr0_d = tmr0_q + 8'd1;
            end else begin
                pre_d = pre_q + 8'd1;
                if ((pre_d & prescale_mask(option_i[OPT_PS_MSB:OPT_PS_LSB])) == 8'h00) begin
                    tmr0_d = tmr0_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr0_q    <= 8'h00;
            pre_q     <= 8'h00;
            inhibit_q <= 2'd0;
        end else begin
            tmr0_q    <= tmr0_d;
            pre_q     <= pre_d;
            inhibit_q <= inhibit_d;
        end
    end

    assign tmr0_o = tmr0_q;

endmodule

// File: rtl/banked_register_file.sv
// PIC16C5x-class data memory: SFRs, common GPRs and FSR-banked GPR pages with
// combinational direct/indirect reads and clocked writes.
module banked_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 11,
    parameter int NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            write_command,
    input  logic [4:0]            file_addr,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic [DATA_WIDTH-1:0] status_in,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  tick_in,
    output logic [DATA_WIDTH-1:0] reg_out,
    output logic [DATA_WIDTH-1:0] status_out,
    output logic [DATA_WIDTH-1:0] fsr_out,
    output logic [5:0]            option_out,
    output logic                  pcl_we
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] fsr_q, fsr_d;
    logic [5:0]            option_q, option_d;
    logic [DATA_WIDTH-1:0] common_q [8];
    logic [DATA_WIDTH-1:0] banked_q [NUM_BANKS][16];

    logic [4:0]        ea;
    logic [BANK_W-1:0] bank;
    logic              file_we;
    logic              common_we;
    logic              banked_we;
    logic              tmr0_load;
    logic [7:0]        tmr0;
    logic              unused_pc_hi;

    assign unused_pc_hi = ^pc_in[PC_WIDTH-1:8];

    // Address and bank always come from the registered FSR, so an FSR write
    // in the same cycle only affects the following access.
    assign ea = (file_addr == ADDR_INDF) ? fsr_q[4:0] : file_addr;

    generate
        if (NUM_BANKS > 1) begin : g_banked
            assign bank = fsr_q[5 +: BANK_W];
        end else begin : g_single
            assign bank = '0;
        end
    endgenerate

    assign file_we   = (write_command == CMD_FILE);
    assign common_we = file_we && (ea[4:3] == 2'b01);
    assign banked_we = file_we && ea[4];
    assign tmr0_load = file_we && (ea == ADDR_TMR0);
    assign pcl_we    = rst && file_we && (ea == ADDR_PCL);

    always_comb begin
        status_d = status_q;
        if (write_command == CMD_STATUS) begin
            status_d = status_in;
        end else if (file_we && (ea == ADDR_STATUS)) begin
            status_d            = write_data_in;
            status_d[STATUS_TO] = status_q[STATUS_TO];
            status_d[STATUS_PD] = status_q[STATUS_PD];
        end
    end

    always_comb begin
        fsr_d = fsr_q;
        if ((write_command == CMD_FSR) || (file_we && (ea == ADDR_FSR))) begin
            fsr_d = write_data_in;
        end
    end

    always_comb begin
        option_d = option_q;
        if (write_command == CMD_OPTION) begin
            option_d = write_data_in[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q <= DATA_WIDTH'(STATUS_RST);
            fsr_q    <= DATA_WIDTH'(FSR_RST);
            option_q <= OPTION_RST;
            for (int i = 0; i < 8; i++) begin
                common_q[i] <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < 16; i++) begin
                    banked_q[b][i] <= '0;
                end
            end
        end else begin
            status_q <= status_d;
            fsr_q    <= fsr_d;
            option_q <= option_d;
            if (common_we) begin
                common_q[ea[2:0]] <= write_data_in;
            end
            if (banked_we) begin
                banked_q[bank][ea[3:0]] <= write_data_in;
            end
        end
    end

    tmr0_prescaler u_tmr0 (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_in),
        .load_i      (tmr0_load),
        .load_data_i (write_data_in[7:0]),
        .option_i    (option_q),
        .tmr0_o      (tmr0)
    );

    always_comb begin
        reg_out = '0;
        if (ea[4]) begin
            reg_out = banked_q[bank][ea[3:0]];
        end else if (ea[3]) begin
            reg_out = common_q[ea[2:0]];
        end else begin
            case (ea)
                ADDR_TMR0:   reg_out = DATA_WIDTH'(tmr0);
                ADDR_PCL:    reg_out = DATA_WIDTH'(pc_in[7:0]);
                ADDR_STATUS: reg_out = status_q;
                ADDR_FSR:    reg_out = fsr_q;
                default:     reg_out = '0;
            endcase
        end
    end

    assign status_out = status_q;
    assign fsr_out    = fsr_q;
    assign option_out = option_q;

endmodule
